lcd1602_reader: RTL and testbench
=================================

LCD1602_READER -- requirements
Module: lcd1602_reader

Interface
REQ-001 The block SHALL have parameter SETUP_CYC, default 4: clk cycles RS/RW held before EN rises (legal 1..255).
REQ-002 The block SHALL have parameter EN_HIGH_CYC, default 12: clk cycles EN held high per read strobe (legal 1..255).
REQ-003 The block SHALL have parameter HOLD_CYC, default 4: clk cycles RS/RW held after EN falls (legal 1..255).
REQ-004 The block SHALL have parameter POLL_MAX, default 200: maximum busy-flag strobes per polled request (legal 1..255).
REQ-005 clk  in  1  system clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 rd_req  in  1  read request, sampled only while rd_ready=1.
REQ-008 rd_rs  in  1  register select for the request: 0 = busy flag/address, 1 = DDRAM/CGRAM data.
REQ-009 rd_poll  in  1  1 = repeat busy-flag reads until BF=0 (honoured only when rd_rs=0).
REQ-010 lcd_data_in  in  8  LCD data bus as driven by the panel during reads.
REQ-011 LCD_RS  out  1  panel register select.
REQ-012 LCD_RW  out  1  panel read/write; 1 only while a read transaction is active.
REQ-013 LCD_EN  out  1  panel enable strobe.
REQ-014 rd_ready  out  1  1 in IDLE; external bus mux hands LCD pins to the writer when 1.
REQ-015 rd_data  out  8  last sampled byte; holds until the next completed transaction.
REQ-016 rd_valid  out  1  one-cycle pulse marking rd_data updated.
REQ-017 bf_timeout  out  1  qualifies rd_valid: polled read ended with BF still 1.

Function
REQ-018 States SHALL be IDLE, SETUP, EN_HI, HOLD, DONE; one 8-bit phase counter and one 8-bit poll counter.
REQ-019 IDLE: rd_req=1 accepts; rd_rs and (rd_poll AND NOT rd_rs) latched; poll counter cleared; next state SETUP.
REQ-020 SETUP: LCD_RS=latched rs, LCD_RW=1, LCD_EN=0, for exactly SETUP_CYC cycles, then EN_HI.
REQ-021 EN_HI: LCD_EN=1, RS/RW unchanged, for exactly EN_HIGH_CYC cycles; lcd_data_in captured into an internal register on the last EN_HI cycle.
REQ-022 HOLD: LCD_EN=0, RS/RW unchanged, for exactly HOLD_CYC cycles; poll counter incremented on HOLD entry.
REQ-023 Leaving HOLD: if poll latched, captured bit7=1 and poll count < POLL_MAX -> SETUP; otherwise -> DONE.
REQ-024 DONE (one cycle): rd_data=captured byte, rd_valid=1, bf_timeout=(poll latched AND bit7=1), LCD_RW=0, LCD_RS=0; next IDLE.
REQ-025 Single-read latency: accept edge at cycle k -> rd_valid high in cycle k+SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+1 (k+21 at defaults).
REQ-026 Each extra poll strobe SHALL add SETUP_CYC+EN_HIGH_CYC+HOLD_CYC cycles (20 at defaults).
REQ-027 rd_ready SHALL be 1 only in IDLE; rd_req outside IDLE SHALL be ignored, not queued.
REQ-028 Back-to-back: rd_req high during DONE ignored; high in the following IDLE cycle accepted; minimum request spacing = latency+1.
REQ-029 rd_rs/rd_poll changes after acceptance SHALL not affect the running transaction.
REQ-030 IDLE outputs: LCD_EN=0, LCD_RW=0, LCD_RS=0, rd_valid=0, bf_timeout=0, rd_data held.
REQ-031 LCD_EN SHALL never be 1 outside EN_HI; RS/RW SHALL not change while LCD_EN=1.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE, clear both counters and capture register, set rd_data=8'h00, rd_valid=0, bf_timeout=0, LCD_EN=0, LCD_RW=0, LCD_RS=0, rd_ready=1.
REQ-033 Reset mid-transaction (any state) SHALL abort with no rd_valid pulse; LCD_EN low from the cycle after the reset edge.
REQ-034 rd_req asserted concurrently with rst SHALL be ignored.

Verification
REQ-035 Single data read: rd_req=1, rd_rs=1, lcd_data_in=8'h41 -> RS=1, RW=1 4 cycles, EN=1 12 cycles, rd_valid at k+21, rd_data=8'h41, bf_timeout=0.
REQ-036 Polled BF: rd_rs=0, rd_poll=1, panel returns 8'h85 for 3 strobes then 8'h05 -> 4 EN pulses, rd_valid at k+81, rd_data=8'h05, bf_timeout=0.
REQ-037 Poll timeout: POLL_MAX=3, panel constant 8'h80 -> exactly 3 EN pulses, rd_valid with rd_data=8'h80, bf_timeout=1.
REQ-038 Poll ignored for data: rd_rs=1, rd_poll=1, data 8'hFF -> exactly one EN pulse, bf_timeout=0.
REQ-039 Reset in EN_HI: rst at 6th EN-high cycle -> EN=0 next cycle, no rd_valid, rd_data=8'h00, rd_ready=1.
REQ-040 Request spam: rd_req held high continuously -> transactions spaced exactly 22 cycles, no EN overlap, RW=0 in each IDLE cycle.

Source files
------------

// File: rtl/lcd1602_reader_if.sv
// Request/response handshake and LCD pin bundle for the LCD1602 read engine.
// The master side is the requester plus panel; the slave side is the reader.
interface lcd1602_reader_if;
  logic       rd_req;
  logic       rd_rs;
  logic       rd_poll;
  logic [7:0] lcd_data_in;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       bf_timeout;

  modport master (
    output rd_req, rd_rs, rd_poll, lcd_data_in,
    input  LCD_RS, LCD_RW, LCD_EN, rd_ready, rd_data, rd_valid, bf_timeout
  );

  modport slave (
    input  rd_req, rd_rs, rd_poll, lcd_data_in,
    output LCD_RS, LCD_RW, LCD_EN, rd_ready, rd_data, rd_valid, bf_timeout
  );
endinterface

// File: rtl/lcd1602_reader.sv
// LCD1602 read engine: one timed RS/RW/EN read strobe per request, optionally
// repeated on the busy flag until it clears or the poll budget runs out.
module lcd1602_reader #(
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned EN_HIGH_CYC = 12,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned POLL_MAX    = 200
) (
  input logic             clk,
  input logic             rst,
  lcd1602_reader_if.slave bus
);

  localparam logic [7:0] SetupLast = 8'(SETUP_CYC - 1);
  localparam logic [7:0] EnLast    = 8'(EN_HIGH_CYC - 1);
  localparam logic [7:0] HoldLast  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] PollMax   = 8'(POLL_MAX);

  typedef enum logic [2:0] {StIdle, StSetup, StEnHi, StHold, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic [7:0] cap_q, cap_d;
  logic [7:0] data_q, data_d;
  logic       rs_q, rs_d;
  logic       poll_q, poll_d;

  logic lcd_rs, lcd_rw, lcd_en, ready, valid, timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      poll_cnt_q <= '0;
      cap_q      <= '0;
      data_q     <= '0;
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      poll_cnt_q <= poll_cnt_d;
      cap_q      <= cap_d;
      data_q     <= data_d;
      rs_q       <= rs_d;
      poll_q     <= poll_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    poll_cnt_d = poll_cnt_q;
    cap_d      = cap_q;
    data_d     = data_q;
    rs_d       = rs_q;
    poll_d     = poll_q;
    lcd_rs     = 1'b0;
    lcd_rw     = 1'b0;
    lcd_en     = 1'b0;
    ready      = 1'b0;
    valid      = 1'b0;
    timeout    = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (bus.rd_req) begin
          rs_d       = bus.rd_rs;
          // Polling only makes sense on the busy-flag register.
          poll_d     = bus.rd_poll & ~bus.rd_rs;
          poll_cnt_d = '0;
          phase_d    = '0;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        lcd_rs = rs_q;
        lcd_rw = 1'b1;
        if (phase_q == SetupLast) begin
          phase_d = '0;
          state_d = StEnHi;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StEnHi: begin
        lcd_rs = rs_q;
        lcd_rw = 1'b1;
        lcd_en = 1'b1;
        if (phase_q == EnLast) begin
          cap_d      = bus.lcd_data_in;
          poll_cnt_d = poll_cnt_q + 8'd1;
          phase_d    = '0;
          state_d    = StHold;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StHold: begin
        lcd_rs = rs_q;
        lcd_rw = 1'b1;
        if (phase_q == HoldLast) begin
          phase_d = '0;
          if (poll_q && cap_q[7] && (poll_cnt_q < PollMax)) begin
            state_d = StSetup;
          end else begin
            data_d  = cap_q;
            state_d = StDone;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StDone: begin
        valid   = 1'b1;
        timeout = poll_q & cap_q[7];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.LCD_RS     = lcd_rs;
  assign bus.LCD_RW     = lcd_rw;
  assign bus.LCD_EN     = lcd_en;
  assign bus.rd_ready   = ready;
  assign bus.rd_data    = data_q;
  assign bus.rd_valid   = valid;
  assign bus.bf_timeout = timeout;

endmodule

// File: tb/tb_lcd1602_reader.sv
// Bench for lcd1602_reader: transaction-level timing model checked every cycle,
// a reactive panel model, directed corner cases and randomized traffic.
module tb_lcd1602_reader;
  localparam int S = 4, E = 12, H = 4, PMAX = 200;
  localparam int P = S + E + H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd1602_reader_if bus ();
  lcd1602_reader_if bus2 ();

  lcd1602_reader dut (.clk(clk), .rst(rst), .bus(bus));
  lcd1602_reader #(.POLL_MAX(3)) dut_to (.clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic [7:0] resp [256];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Model: a transaction is an accept cycle, n strobes of P cycles each, then one done cycle.
  bit         m_busy = 1'b0;
  int         m_d = 0, m_n = 1;
  logic       m_rs = 1'b0, m_to = 1'b0;
  logic [7:0] m_data = 8'h00, m_rd_data = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      m_rd_data = 8'h00;
    end else if (!m_busy) begin
      if (bus.rd_req) begin
        m_busy = 1'b1;
        m_d = 1;
        m_rs = bus.rd_rs;
        m_n = 1;
        if (bus.rd_poll && !bus.rd_rs)
          while (m_n < PMAX && resp[m_n-1][7]) m_n++;
        m_data = resp[m_n-1];
        m_to = bus.rd_poll && !bus.rd_rs && m_data[7];
      end
    end else if (m_d == m_n * P + 1) begin
      m_busy = 1'b0;
    end else begin
      m_d++;
      if (m_d == m_n * P + 1) m_rd_data = m_data;
    end
  end

  logic [13:0] exp_v, got_v;
  int q;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (!m_busy) begin
        exp_v = {6'b100000, m_rd_data};
      end else if (m_d <= m_n * P) begin
        q = (m_d - 1) % P;
        exp_v = {1'b0, m_rs, 1'b1, (q >= S && q < S + E), 2'b00, m_rd_data};
      end else begin
        exp_v = {4'b0000, 1'b1, m_to, m_rd_data};
      end
      got_v = {bus.rd_ready, bus.LCD_RS, bus.LCD_RW, bus.LCD_EN,
               bus.rd_valid, bus.bf_timeout, bus.rd_data};
      check("cycle_outputs", 32'(got_v), 32'(exp_v));
    end
  end

  // Panel: presents resp[i] on the i-th EN pulse of a transaction, junk otherwise.
  int pidx = 0, en_rises = 0, valid_cnt = 0, acc_cyc = 0, valid_cyc = 0;
  int en2_rises = 0, valid2_cnt = 0, acc2_cyc = 0, valid2_cyc = 0;
  logic en_prev = 1'b0, en2_prev = 1'b0;
  logic [7:0] valid_data = 8'h00, valid2_data = 8'h00;
  logic valid_to = 1'b0, valid2_to = 1'b0;

  initial begin
    bus.lcd_data_in = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.rd_ready === 1'b1) pidx = 0;
      if (bus.rd_ready === 1'b1 && bus.rd_req && !rst) acc_cyc = cyc;
      if (bus.LCD_EN === 1'b1 && !en_prev) begin
        bus.lcd_data_in = resp[pidx & 255];
        pidx++;
        en_rises++;
      end else if (bus.LCD_EN !== 1'b1) begin
        bus.lcd_data_in = 8'($urandom);
      end
      en_prev = (bus.LCD_EN === 1'b1);
      if (bus.rd_valid === 1'b1) begin
        valid_cnt++;
        valid_cyc = cyc;
        valid_data = bus.rd_data;
        valid_to = bus.bf_timeout;
      end
      if (bus2.rd_ready === 1'b1 && bus2.rd_req && !rst) acc2_cyc = cyc;
      if (bus2.LCD_EN === 1'b1 && !en2_prev) en2_rises++;
      en2_prev = (bus2.LCD_EN === 1'b1);
      if (bus2.rd_valid === 1'b1) begin
        valid2_cnt++;
        valid2_cyc = cyc;
        valid2_data = bus2.rd_data;
        valid2_to = bus2.bf_timeout;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_txn(input logic rs, input logic poll, output int lat, output int pulses,
                         output logic [7:0] data, output logic to, output bit ok);
    int v0, e0;
    v0 = valid_cnt;
    e0 = en_rises;
    bus.rd_req = 1'b1;
    bus.rd_rs = rs;
    bus.rd_poll = poll;
    step();
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      // Inputs wiggle mid-transaction; none of it may matter.
      bus.rd_req = 1'($urandom);
      bus.rd_rs = 1'($urandom);
      bus.rd_poll = 1'($urandom);
      step();
      if (valid_cnt != v0) ok = 1'b1;
    end
    bus.rd_req = 1'b0;
    bus.rd_rs = 1'b0;
    bus.rd_poll = 1'b0;
    lat = valid_cyc - acc_cyc;
    pulses = en_rises - e0;
    data = valid_data;
    to = valid_to;
  endtask

  int lat, pulses, v0, prev_vc;
  logic [7:0] data;
  logic to;
  bit ok;

  initial begin
    bus.rd_req = 1'b0;
    bus.rd_rs = 1'b0;
    bus.rd_poll = 1'b0;
    bus2.rd_req = 1'b0;
    bus2.rd_rs = 1'b0;
    bus2.rd_poll = 1'b0;
    bus2.lcd_data_in = 8'h80;
    for (int i = 0; i < 256; i++) resp[i] = 8'h00;
    rst = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    check("reset_ready", 32'(bus.rd_ready), 32'd1);
    check("reset_rd_data", 32'(bus.rd_data), 32'h00);
    check("reset_en_rw", 32'({bus.LCD_EN, bus.LCD_RW, bus.LCD_RS}), 32'd0);
    rst = 1'b0;
    step();

    // Single data read.
    resp[0] = 8'h41;
    run_txn(1'b1, 1'b0, lat, pulses, data, to, ok);
    check("single_done", 32'(ok), 32'd1);
    check("single_latency", 32'(lat), 32'd21);
    check("single_pulses", 32'(pulses), 32'd1);
    check("single_data", 32'(data), 32'h41);
    check("single_timeout", 32'(to), 32'd0);

    // Busy flag clears on the fourth strobe.
    resp[0] = 8'h85; resp[1] = 8'h85; resp[2] = 8'h85; resp[3] = 8'h05;
    run_txn(1'b0, 1'b1, lat, pulses, data, to, ok);
    check("poll_done", 32'(ok), 32'd1);
    check("poll_latency", 32'(lat), 32'd81);
    check("poll_pulses", 32'(pulses), 32'd4);
    check("poll_data", 32'(data), 32'h05);
    check("poll_timeout", 32'(to), 32'd0);

    // Poll request on the data register reads once.
    for (int i = 0; i < 256; i++) resp[i] = 8'hFF;
    run_txn(1'b1, 1'b1, lat, pulses, data, to, ok);
    check("datapoll_pulses", 32'(pulses), 32'd1);
    check("datapoll_timeout", 32'(to), 32'd0);
    check("datapoll_data", 32'(data), 32'hFF);

    // Poll budget of 3 on a panel stuck busy.
    v0 = valid2_cnt;
    bus2.rd_req = 1'b1;
    bus2.rd_poll = 1'b1;
    step();
    bus2.rd_req = 1'b0;
    for (int i = 0; i < 500 && valid2_cnt == v0; i++) step();
    check("to3_done", 32'(valid2_cnt - v0), 32'd1);
    check("to3_pulses", 32'(en2_rises), 32'd3);
    check("to3_latency", 32'(valid2_cyc - acc2_cyc), 32'd61);
    check("to3_data", 32'(valid2_data), 32'h80);
    check("to3_timeout", 32'(valid2_to), 32'd1);

    // Default poll budget exhausted.
    for (int i = 0; i < 256; i++) resp[i] = 8'h80;
    run_txn(1'b0, 1'b1, lat, pulses, data, to, ok);
    check("to200_pulses", 32'(pulses), 32'd200);
    check("to200_latency", 32'(lat), 32'd4001);
    check("to200_timeout", 32'(to), 32'd1);

    // Reset on the sixth EN-high cycle, with a request alongside it.
    resp[0] = 8'h5A;
    v0 = valid_cnt;
    bus.rd_req = 1'b1;
    bus.rd_rs = 1'b1;
    step();
    bus.rd_req = 1'b0;
    for (int i = 0; i < 40 && bus.LCD_EN !== 1'b1; i++) step();
    repeat (5) step();
    check("pre_reset_en", 32'(bus.LCD_EN), 32'd1);
    rst = 1'b1;
    bus.rd_req = 1'b1;
    step();
    rst = 1'b0;
    bus.rd_req = 1'b0;
    check("post_reset_en", 32'(bus.LCD_EN), 32'd0);
    check("post_reset_ready", 32'(bus.rd_ready), 32'd1);
    check("post_reset_data", 32'(bus.rd_data), 32'h00);
    repeat (30) step();
    check("reset_no_valid", 32'(valid_cnt - v0), 32'd0);

    // Request held high continuously.
    for (int i = 0; i < 256; i++) resp[i] = 8'($urandom);
    v0 = en_rises;
    bus.rd_req = 1'b1;
    bus.rd_rs = 1'b1;
    prev_vc = 0;
    for (int t = 0; t < 5; t++) begin
      int vs;
      vs = valid_cnt;
      for (int i = 0; i < 100 && valid_cnt == vs; i++) step();
      check("spam_valid", 32'(valid_cnt - vs), 32'd1);
      if (t > 0) check("spam_spacing", 32'(valid_cyc - prev_vc), 32'd22);
      prev_vc = valid_cyc;
    end
    bus.rd_req = 1'b0;
    check("spam_pulses", 32'(en_rises - v0), 32'd5);
    repeat (25) step();

    // Randomized traffic, resets included.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!m_busy)
        for (int i = 0; i < 256; i++) resp[i] = {($urandom_range(0, 2) != 0), 7'($urandom)};
      bus.rd_req = ($urandom_range(0, 3) == 0);
      bus.rd_rs = 1'($urandom);
      bus.rd_poll = 1'($urandom);
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    bus.rd_req = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
